// File: rtl/light_pkg.sv
// light_pkg: shared state type, width helper and default parameters for light_toggle_ctrl
package light_pkg;
  typedef enum logic [1:0] {INIT, IDLE, LOCKOUT} state_e;
  localparam int DEF_N_SW = 2;
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_LOCKOUT_CYCLES = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  function automatic int clog2w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop sync + debounce of one raw switch; ports clk, rst_n, sw (raw), init_load (track synced level, no pulse), chg (registered pulse per accepted level change)
module sw_debounce
  import light_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  input  logic init_load,
  output logic chg
);
  localparam int CW = clog2w(DEB_CYCLES);
  logic s1_q, s2_q, lvl_q, lvl_d, chg_q, chg_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    accept = !init_load && s2_q != lvl_q && cnt_q == CW'(DEB_CYCLES - 1);
    lvl_d = init_load || accept ? s2_q : lvl_q;
    chg_d = accept;
    cnt_d = init_load || accept || s2_q == lvl_q ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      lvl_q <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
      lvl_q <= lvl_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end
  assign chg = chg_q;
endmodule

// File: rtl/light_toggle_ctrl.sv
// light_toggle_ctrl: multi-way light toggle; ports clk, rst_n, sw[N_SW] raw switches, force_off -> light, toggle_vld/toggle_src grant pulse, timeout_off pulse, busy (INIT/LOCKOUT)
module light_toggle_ctrl
  import light_pkg::*;
#(
  parameter int N_SW = DEF_N_SW,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SW_W = clog2w(N_SW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  input  logic            force_off,
  output logic            light,
  output logic            toggle_vld,
  output logic [SW_W-1:0] toggle_src,
  output logic            timeout_off,
  output logic            busy
);
  localparam int INIT_LAST = DEB_CYCLES + 1;
  localparam int CNT_MAX = INIT_LAST > LOCKOUT_CYCLES - 1 ? INIT_LAST : LOCKOUT_CYCLES - 1;
  localparam int CW = clog2w(CNT_MAX + 1);
  localparam int TW = clog2w(TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [N_SW-1:0] chg, pend_q, pend_d, gnt_mask;
  logic [SW_W-1:0] last_q, last_d, src_q, src_d, gnt_idx;
  logic light_q, light_d, vld_q, vld_d, tmo_q, tmo_d;
  logic gnt_hit, can_grant, tmo, grant;
  int best, off;
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw       (sw[i]),
      .init_load(state_q == INIT),
      .chg      (chg[i])
    );
  end
  // round-robin: pick the pending index with the smallest distance past last_q
  always_comb begin
    best = N_SW;
    off = 0;
    gnt_idx = '0;
    for (int k = 0; k < N_SW; k++) begin
      off = (k + N_SW - 1 - int'(last_q)) % N_SW;
      if (pend_q[k] && off < best) begin
        best = off;
        gnt_idx = SW_W'(k);
      end
    end
    gnt_hit = best < N_SW;
  end
  // the last LOCKOUT cycle also serves as an IDLE decision so back-to-back grants are LOCKOUT_CYCLES apart
  always_comb begin
    tmo = TIMEOUT_CYCLES != 0 && light_q && idle_q == TW'(TIMEOUT_CYCLES - 1);
    can_grant = state_q == IDLE || (state_q == LOCKOUT && cnt_q == '0);
    grant = can_grant && gnt_hit && !force_off && !tmo;
    gnt_mask = grant ? N_SW'(1) << gnt_idx : '0;
    state_d = state_q;
    cnt_d = cnt_q;
    light_d = light_q;
    pend_d = (pend_q & ~gnt_mask) ^ chg;
    last_d = last_q;
    src_d = src_q;
    vld_d = 1'b0;
    tmo_d = 1'b0;
    idle_d = light_q ? idle_q + 1'b1 : '0;
    if (state_q == INIT) begin
      pend_d = pend_q;
      cnt_d = cnt_q == CW'(INIT_LAST) ? '0 : cnt_q + 1'b1;
      state_d = cnt_q == CW'(INIT_LAST) ? IDLE : INIT;
    end else if (force_off) begin
      state_d = IDLE;
      cnt_d = '0;
      light_d = 1'b0;
      pend_d = '0;
      idle_d = '0;
    end else begin
      if (state_q == LOCKOUT) begin
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? IDLE : LOCKOUT;
      end
      if (tmo) begin
        light_d = 1'b0;
        tmo_d = 1'b1;
        idle_d = '0;
      end
      if (grant) begin
        light_d = !light_q;
        vld_d = 1'b1;
        src_d = gnt_idx;
        last_d = gnt_idx;
        cnt_d = CW'(LOCKOUT_CYCLES - 1);
        state_d = LOCKOUT;
        idle_d = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      idle_q <= '0;
      pend_q <= '0;
      last_q <= '0;
      src_q <= '0;
      light_q <= 1'b0;
      vld_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idle_q <= idle_d;
      pend_q <= pend_d;
      last_q <= last_d;
      src_q <= src_d;
      light_q <= light_d;
      vld_q <= vld_d;
      tmo_q <= tmo_d;
    end
  end
  assign light = light_q;
  assign toggle_vld = vld_q;
  assign toggle_src = src_q;
  assign timeout_off = tmo_q;
  assign busy = state_q != IDLE;
endmodule
